// File: rtl/mips_pkg.sv
// Shared encodings for the memory-port arbiter: bus owner states, tie-break
// preference and master indices.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        LDR_OWN = 2'd2
    } own_t;

    typedef enum logic [1:0] {
        PREF_NONE = 2'd0,
        PREF_CPU  = 2'd1,
        PREF_LDR  = 2'd2
    } pref_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_LDR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way tie-break used when both masters request in IDLE.
module arb_pick
    import mips_pkg::*;
#(
    parameter int unsigned CPU_PRIO = 1
) (
    input  pref_t i_prefer,
    input  logic  i_last_served,
    output logic  o_winner
);

    always_comb begin
        o_winner = M_CPU;
        case (i_prefer)
            PREF_CPU: o_winner = M_CPU;
            PREF_LDR: o_winner = M_LDR;
            default: begin
                if (CPU_PRIO != 0) o_winner = M_CPU;
                else               o_winner = (i_last_served == M_CPU) ? M_LDR : M_CPU;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU and the loader, one access
// per cycle, with optional locked bursts bounded by MAX_BURST.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CPU_PRIO  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST - 1);

    own_t              r_state, w_state_nxt;
    pref_t             r_prefer, w_prefer_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_last_served;
    logic              r_cpu_rvalid, r_ldr_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata, r_ldr_rdata;
    logic              w_tie_winner;
    logic              w_cpu_gnt, w_ldr_gnt;

    arb_pick #(.CPU_PRIO(CPU_PRIO)) u_pick (
        .i_prefer      (r_prefer),
        .i_last_served (r_last_served),
        .o_winner      (w_tie_winner)
    );

    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_ldr_gnt    = 1'b0;
        w_state_nxt  = r_state;
        w_prefer_nxt = r_prefer;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (cpu_req && ldr_req) begin
                    w_cpu_gnt = (w_tie_winner == M_CPU);
                    w_ldr_gnt = (w_tie_winner == M_LDR);
                end else begin
                    w_cpu_gnt = cpu_req;
                    w_ldr_gnt = ldr_req;
                end
                w_cnt_nxt = '0;
                if (w_cpu_gnt || w_ldr_gnt) w_prefer_nxt = PREF_NONE;
                if (w_cpu_gnt && cpu_lock) w_state_nxt = CPU_OWN;
                if (w_ldr_gnt && ldr_lock) w_state_nxt = LDR_OWN;
            end
            CPU_OWN: begin
                // The bus stays held while locked even if the owner is not requesting.
                w_cpu_gnt = cpu_req;
                if (!cpu_lock) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_MAX && ldr_req) begin
                    w_state_nxt  = IDLE;
                    w_prefer_nxt = PREF_LDR;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            LDR_OWN: begin
                w_ldr_gnt = ldr_req;
                if (!ldr_lock) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_MAX && cpu_req) begin
                    w_state_nxt  = IDLE;
                    w_prefer_nxt = PREF_CPU;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cpu_gnt    = w_cpu_gnt & ~reset;
    assign ldr_gnt    = w_ldr_gnt & ~reset;
    assign mem_we     = (cpu_gnt & cpu_we) | (ldr_gnt & ldr_we);
    assign mem_addr   = ldr_gnt ? ldr_addr  : cpu_addr;
    assign mem_wdata  = ldr_gnt ? ldr_wdata : cpu_wdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ldr_rdata  = r_ldr_rdata;
    assign ldr_rvalid = r_ldr_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_prefer      <= PREF_NONE;
            r_cnt         <= '0;
            r_last_served <= M_LDR;
            r_cpu_rvalid  <= 1'b0;
            r_ldr_rvalid  <= 1'b0;
            r_cpu_rdata   <= '0;
            r_ldr_rdata   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prefer     <= w_prefer_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
            r_ldr_rvalid <= w_ldr_gnt & ~ldr_we;
            if (w_cpu_gnt) r_last_served <= M_CPU;
            if (w_ldr_gnt) r_last_served <= M_LDR;
            if (w_cpu_gnt && !cpu_we) r_cpu_rdata <= mem_rdata;
            if (w_ldr_gnt && !ldr_we) r_ldr_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: ownership/burst model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, cpu_lock = 0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        ldr_req = 0, ldr_we = 0, ldr_lock = 0;
    logic [31:0] ldr_addr = '0, ldr_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_we;
    logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_gnt1, cpu_rvalid1, ldr_gnt1, ldr_rvalid1, mem_we1;
    logic [31:0] cpu_rdata1, ldr_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    logic [31:0] mem [0:63];
    int n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB), .CPU_PRIO(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB), .CPU_PRIO(0)) dut_rr (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt1), .cpu_rdata(cpu_rdata1), .cpu_rvalid(cpu_rvalid1),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt1), .ldr_rdata(ldr_rdata1), .ldr_rvalid(ldr_rvalid1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    assign mem_rdata  = mem[mem_addr[7:2]];
    assign mem_rdata1 = mem[mem_addr1[7:2]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: owner 0=none 1=CPU 2=LDR, hold length, pending preference.
    int          m_own = 0, m_cnt = 0, m_pref = 0;
    logic        m_rv_c = 0, m_rv_l = 0;
    logic [31:0] m_rd_c = '0, m_rd_l = '0;

    function automatic logic req_of(int m);   return (m == 1) ? cpu_req   : ldr_req;   endfunction
    function automatic logic we_of(int m);    return (m == 1) ? cpu_we    : ldr_we;    endfunction
    function automatic logic lock_of(int m);  return (m == 1) ? cpu_lock  : ldr_lock;  endfunction
    function automatic logic [31:0] addr_of(int m);  return (m == 1) ? cpu_addr  : ldr_addr;  endfunction
    function automatic logic [31:0] wdat_of(int m);  return (m == 1) ? cpu_wdata : ldr_wdata; endfunction

    function automatic int winner();
        if (reset) return 0;
        if (m_own != 0) return req_of(m_own) ? m_own : 0;
        if (cpu_req && ldr_req) return (m_pref != 0) ? m_pref : 1;
        if (cpu_req) return 1;
        if (ldr_req) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        int w;
        logic [31:0] a;
        if (reset) begin
            m_own <= 0; m_cnt <= 0; m_pref <= 0;
            m_rv_c <= 0; m_rv_l <= 0; m_rd_c <= '0; m_rd_l <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else begin
            w = winner();
            a = (w != 0) ? addr_of(w) : cpu_addr;
            m_rv_c <= (w == 1) && !cpu_we;
            m_rv_l <= (w == 2) && !ldr_we;
            if (w == 1 && !cpu_we) m_rd_c <= mem[a[7:2]];
            if (w == 2 && !ldr_we) m_rd_l <= mem[a[7:2]];
            if (w != 0 && we_of(w)) mem[a[7:2]] <= wdat_of(w);
            if (m_own == 0) begin
                m_cnt <= 0;
                if (w != 0) begin
                    m_pref <= 0;
                    if (lock_of(w)) m_own <= w;
                end
            end else if (!lock_of(m_own)) begin
                m_own <= 0;
            end else if (m_cnt == MB - 1 && req_of(3 - m_own)) begin
                m_own <= 0;
                m_pref <= 3 - m_own;
            end else if (m_cnt < MB - 1) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        w = winner();
        chk("cpu_gnt", cpu_gnt, w == 1);
        chk("ldr_gnt", ldr_gnt, w == 2);
        chk("mem_we", mem_we, (w != 0) && we_of(w));
        chk("mem_addr", mem_addr, (w == 2) ? ldr_addr : cpu_addr);
        chk("mem_wdata", mem_wdata, (w == 2) ? ldr_wdata : cpu_wdata);
        chk("cpu_rvalid", cpu_rvalid, m_rv_c);
        chk("ldr_rvalid", ldr_rvalid, m_rv_l);
        chk("cpu_rdata", cpu_rdata, m_rd_c);
        chk("ldr_rdata", ldr_rdata, m_rd_l);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, k;
        logic [1:0] g [0:2];

        cyc(); cyc();
        #3;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
        chk("rst_rdata", cpu_rdata, 0);
        cyc();
        reset = 0;

        // CPU read, then write and read back
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0040_0000;
        #3 chk("cpu_rd_gnt", cpu_gnt, 1);
        cyc(); cpu_req = 0;
        #3 chk("cpu_rd_valid", cpu_rvalid, 1);
        chk("cpu_rd_data", cpu_rdata, 32'hC0DE_0000);
        cyc(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0040_0004; cpu_wdata = 32'hA5A5_0001;
        #3 chk("cpu_wr_we", mem_we, 1);
        cyc(); cpu_we = 0;
        cyc(); cpu_req = 0;
        #3 chk("cpu_readback", cpu_rdata, 32'hA5A5_0001);

        // simultaneous requests, CPU priority
        cyc(); cpu_req = 1; ldr_req = 1; ldr_we = 0; ldr_addr = 32'h8; cpu_addr = 32'h0;
        #3 chk("tie_cpu_first", {cpu_gnt, ldr_gnt}, 2'b10);
        cyc(); cpu_req = 0;
        #3 chk("tie_ldr_next", ldr_gnt, 1);
        cyc(); ldr_req = 0;
        #3 chk("tie_ldr_data", ldr_rdata, 32'hC0DE_0002);

        // loader locked burst with CPU waiting
        cyc(); k = 0;
        ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 32'h80; ldr_wdata = 32'hD00D_0000;
        #3 chk("burst_first", ldr_gnt, 1);
        k = 1;
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0040_0000;
        ldr_addr = 32'h80 + 32'(4 * k); ldr_wdata = 32'hD00D_0000 + 32'(k);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #3;
            if (cpu_gnt) break;
            if (ldr_gnt) begin n++; k++; end
            cyc();
            ldr_addr = 32'h80 + 32'(4 * k); ldr_wdata = 32'hD00D_0000 + 32'(k);
        end
        chk("burst_len", n, 4);
        chk("forced_release", {cpu_gnt, ldr_gnt}, 2'b10);
        cyc(); cpu_req = 0;
        #3 chk("ldr_resume", ldr_gnt, 1);
        k += int'(ldr_gnt);
        for (int j = 0; j < 4; j++) begin
            cyc();
            ldr_addr = 32'h80 + 32'(4 * k); ldr_wdata = 32'hD00D_0000 + 32'(k);
            ldr_lock = (k < 9);
            #3 k += int'(ldr_gnt);
        end
        chk("burst_total", k, 10);
        cyc(); ldr_req = 0; ldr_lock = 0; ldr_we = 0;
        cpu_req = 1; cpu_addr = 32'h80;
        cyc(); cpu_req = 0;
        #3 chk("burst_word0", cpu_rdata, 32'hD00D_0000);

        // CPU holds lock without requesting
        cyc(); cpu_req = 1; cpu_lock = 1; cpu_addr = 32'h0;
        cyc(); cpu_req = 0; ldr_req = 1; ldr_we = 0; ldr_addr = 32'h84;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (ldr_gnt) break;
            n++;
            cyc();
        end
        chk("idle_hold_len", n, MB);
        chk("idle_hold_ldr", ldr_gnt, 1);
        cyc(); ldr_req = 0; cpu_lock = 0;
        #3 chk("idle_hold_data", ldr_rdata, 32'hD00D_0001);

        // async reset in the middle of a loader burst
        cyc(); ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 32'h90; ldr_wdata = 32'h5555_0001;
        cyc(); ldr_addr = 32'h94; ldr_wdata = 32'hBAD0_BAD0;
        #1 chk("pre_rst_gnt", ldr_gnt, 1);
        reset = 1;
        #1 chk("rst_drop", {ldr_gnt, mem_we, ldr_rvalid}, 3'b000);
        cyc(); reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h94;
        #3 chk("post_rst_cpu", {cpu_gnt, ldr_gnt}, 2'b10);
        cyc(); cpu_req = 0;
        #3 chk("post_rst_data", cpu_rdata, 32'hC0DE_0025);
        cyc(); ldr_req = 0; ldr_lock = 0; ldr_we = 0;

        // round-robin instance from a fresh reset
        cyc(); reset = 1;
        cyc(); reset = 0;
        cpu_req = 1; ldr_req = 1; cpu_addr = 32'h0; ldr_addr = 32'h80;
        for (int i = 0; i < 3; i++) begin
            #3 g[i] = {cpu_gnt1, ldr_gnt1};
            cyc();
        end
        chk("rr_0", g[0], 2'b10);
        chk("rr_1", g[1], 2'b01);
        chk("rr_2", g[2], 2'b10);
        cpu_req = 0; ldr_req = 0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
